snake_engine: RTL

Parametrised snake movement/collision engine for the snake game datapath. Holds the body as a shift array of grid coordinates, advances it one cell per speed tick in RUNNING, and reports wall hits, self hits, food eaten and the win condition (full length). Sits between the game-state controller/direction decoder and the VGA renderer and food generator; replaces the fixed 32x24, 64-segment engine with configurable grid, depth, speed curve and wall/wrap mode.

---
 rtl/snake_if.sv | 36 +++
 rtl/snake_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/snake_if.sv
// Control/feedback bundle between the game controller side and the snake engine.
// The master drives game control and food; the slave (engine) returns body state and event flags.
interface snake_if #(
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
);
  logic [1:0]             game_state;
  logic                   pause;
  logic                   slow;
  logic [1:0]             dir_req;
  logic [X_W-1:0]         food_x;
  logic [Y_W-1:0]         food_y;
  logic                   food_valid;

  logic [1:0]             cur_dir;
  logic [MAX_LEN*X_W-1:0] snake_x_flat;
  logic [MAX_LEN*Y_W-1:0] snake_y_flat;
  logic [LEN_W-1:0]       snake_len;
  logic                   step;
  logic                   eat;
  logic                   hit_wall;
  logic                   hit_self;
  logic                   full;

  modport master (
    output game_state, pause, slow, dir_req, food_x, food_y, food_valid,
    input  cur_dir, snake_x_flat, snake_y_flat, snake_len, step, eat, hit_wall, hit_self, full
  );

  modport slave (
    input  game_state, pause, slow, dir_req, food_x, food_y, food_valid,
    output cur_dir, snake_x_flat, snake_y_flat, snake_len, step, eat, hit_wall, hit_self, full
  );
endinterface

// File: rtl/snake_engine.sv
// Snake movement/collision engine: shift-array body advanced one cell per speed tick,
// with wall/self collision, food eating, growth-driven speedup and full-length detection.
module snake_engine #(
  parameter int          GRID_W      = 32,
  parameter int          GRID_H      = 24,
  parameter int          X_W         = 5,
  parameter int          Y_W         = 5,
  parameter int          MAX_LEN     = 64,
  parameter int          LEN_W       = 7,
  parameter int          INIT_LEN    = 3,
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned SPEEDUP     = 750_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000,
  parameter bit          WRAP        = 1'b0
) (
  input logic   clk,
  input logic   rst,
  snake_if.slave bus
);

  typedef enum logic [1:0] {
    GS_RUNNING = 2'b00,
    GS_DIE     = 2'b01,
    GS_INITIAL = 2'b10,
    GS_DIE_ALT = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [X_W-1:0] CX      = X_W'(GRID_W / 2 - 1);
  localparam logic [Y_W-1:0] CY      = Y_W'(GRID_H / 2 - 3);
  localparam logic [X_W-1:0] X_LAST  = X_W'(GRID_W - 1);
  localparam logic [X_W-1:0] X_INNER = X_W'(GRID_W - 2);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(GRID_H - 1);
  localparam logic [Y_W-1:0] Y_INNER = Y_W'(GRID_H - 2);

  logic [X_W-1:0]   seg_x [MAX_LEN];
  logic [Y_W-1:0]   seg_y [MAX_LEN];
  logic [LEN_W-1:0] len;
  dir_t             cur_dir;
  logic [31:0]      cnt;
  logic             step, eat, hit_wall, hit_self, full;

  game_state_t      gs;
  dir_t             dir_req, dir_rev, dir_nxt;
  logic [31:0]      base_p, dec_p, period;
  logic             active, tick;
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic             wall, eat_hit, self_hit;
  logic [LEN_W-1:0] self_lim;

  assign gs      = game_state_t'(bus.game_state);
  assign dir_req = dir_t'(bus.dir_req);
  assign dir_rev = dir_t'({cur_dir[1], ~cur_dir[0]});
  assign dir_nxt = (dir_req == dir_rev) ? cur_dir : dir_req;

  // Step period shrinks with length; clamp both on underflow and on the floor.
  always_comb begin
    base_p = bus.slow ? 32'(2 * BASE_PERIOD) : BASE_PERIOD;
    dec_p  = 32'(SPEEDUP * 32'(len - LEN_W'(INIT_LEN)));
    if (dec_p > base_p || (base_p - dec_p) < MIN_PERIOD) period = MIN_PERIOD;
    else                                                  period = base_p - dec_p;
  end

  assign active = (gs == GS_RUNNING) && !bus.pause && !hit_wall && !hit_self && !full;
  assign tick   = active && (cnt >= period - 32'd1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nx   = seg_x[0];
    ny   = seg_y[0];
    wall = 1'b0;
    case (dir_nxt)
      DIR_UP:    ny = seg_y[0] - Y_W'(1);
      DIR_DOWN:  ny = seg_y[0] + Y_W'(1);
      DIR_RIGHT: nx = seg_x[0] + X_W'(1);
      default:   nx = seg_x[0] - X_W'(1);
    endcase
    if (WRAP) begin
      if (nx == '0)          nx = X_INNER;
      else if (nx == X_LAST) nx = X_W'(1);
      if (ny == '0)          ny = Y_INNER;
      else if (ny == Y_LAST) ny = Y_W'(1);
    end else begin
      wall = (nx == '0) || (nx == X_LAST) || (ny == '0) || (ny == Y_LAST);
    end
  end

  // The tail cell only vacates when the snake does not grow on this move.
  always_comb begin
    eat_hit  = bus.food_valid && (nx == bus.food_x) && (ny == bus.food_y);
    self_lim = eat_hit ? len : len - LEN_W'(1);
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < self_lim && seg_x[i] == nx && seg_y[i] == ny) self_hit = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the body array is reset because reset defines the starting snake, not just control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= (k < INIT_LEN) ? CX : '0;
        seg_y[k] <= (k < INIT_LEN) ? CY + Y_W'(k) : '0;
      end
      len      <= LEN_W'(INIT_LEN);
      cur_dir  <= DIR_UP;
      cnt      <= '0;
      step     <= 1'b0;
      eat      <= 1'b0;
      hit_wall <= 1'b0;
      hit_self <= 1'b0;
      full     <= 1'b0;
    end else if (gs == GS_INITIAL) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= (k < INIT_LEN) ? CX : '0;
        seg_y[k] <= (k < INIT_LEN) ? CY + Y_W'(k) : '0;
      end
      len      <= LEN_W'(INIT_LEN);
      cur_dir  <= DIR_UP;
      cnt      <= '0;
      step     <= 1'b0;
      eat      <= 1'b0;
      hit_wall <= 1'b0;
      hit_self <= 1'b0;
      full     <= 1'b0;
    end else begin
      step <= 1'b0;
      eat  <= 1'b0;
      if (tick) begin
        cnt <= '0;
        if (wall) begin
          hit_wall <= 1'b1;
        end else if (self_hit) begin
          hit_self <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len || (eat_hit && LEN_W'(i) == len)) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          cur_dir  <= dir_nxt;
          step     <= 1'b1;
          if (eat_hit) begin
            len <= len + LEN_W'(1);
            eat <= 1'b1;
            if (len + LEN_W'(1) == LEN_W'(MAX_LEN)) full <= 1'b1;
          end
        end
      end else if (active) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign bus.snake_x_flat[g*X_W +: X_W] = seg_x[g];
    assign bus.snake_y_flat[g*Y_W +: Y_W] = seg_y[g];
  end

  assign bus.snake_len = len;
  assign bus.cur_dir   = cur_dir;
  assign bus.step      = step;
  assign bus.eat       = eat;
  assign bus.hit_wall  = hit_wall;
  assign bus.hit_self  = hit_self;
  assign bus.full      = full;

endmodule
